// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_gen
// Description : Dual-channel 50 Hz hobby-servo PWM generator. Requested X/Y
//               widths are clamped to the servo-safe range, slew-limited per
//               frame, and latched only at frame boundaries so that pulses
//               already on the pins are never truncated or stretched.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_gen #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int CENTER_US   = 1500,
  parameter int STEP_US     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] x_pulse_us,
  input  logic [10:0] y_pulse_us,
  output logic        servo_x,
  output logic        servo_y,
  output logic        frame_start,
  output logic        settled
);

  localparam int              c_TICKS    = CLK_FREQ_HZ / 1_000_000;
  localparam int              c_PW       = (c_TICKS > 1) ? $clog2(c_TICKS) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(c_TICKS - 1);
  localparam logic [14:0]     c_US_LAST  = 15'(FRAME_US - 1);
  localparam logic [10:0]     c_MIN      = 11'(MIN_US);
  localparam logic [10:0]     c_MAX      = 11'(MAX_US);
  localparam logic [10:0]     c_CENTER   = 11'(CENTER_US);
  localparam logic [11:0]     c_STEP     = 12'(STEP_US);

  // Limit a requested width to the legal servo range.
  function automatic logic [10:0] f_clamp(input logic [10:0] v);
    if (v < c_MIN)      f_clamp = c_MIN;
    else if (v > c_MAX) f_clamp = c_MAX;
    else                f_clamp = v;
  endfunction

  // Move the active width toward its target by at most one step. The math is
  // one bit wider than the widths so neither the add nor the subtract wraps.
  function automatic logic [10:0] f_slew(input logic [10:0] act, input logic [10:0] tgt);
    logic [11:0] a;
    logic [11:0] t;
    a = {1'b0, act};
    t = {1'b0, tgt};
    if (c_STEP == 12'd0)       f_slew = tgt;
    else if (t > a + c_STEP)   f_slew = 11'(a + c_STEP);
    else if (t + c_STEP < a)   f_slew = 11'(a - c_STEP);
    else                       f_slew = tgt;
  endfunction

  logic [c_PW-1:0] r_pre_cnt;
  logic [14:0]     r_us_cnt;
  logic [10:0]     r_w_x;
  logic [10:0]     r_w_y;
  logic            r_en;
  logic            r_servo_x;
  logic            r_servo_y;
  logic            r_frame_start;
  logic            r_settled;

  logic            w_us_tick;
  logic            w_boundary;
  logic [c_PW-1:0] w_pre_next;
  logic [14:0]     w_us_next;
  logic [10:0]     w_tgt_x;
  logic [10:0]     w_tgt_y;
  logic [10:0]     w_wx_next;
  logic [10:0]     w_wy_next;
  logic            w_en_next;

  // Counter advance and boundary-time sampling of the upstream request.
  always_comb begin
    w_us_tick  = (r_pre_cnt == c_PRE_LAST);
    w_boundary = w_us_tick && (r_us_cnt == c_US_LAST);
    w_pre_next = w_us_tick ? '0 : r_pre_cnt + c_PW'(1);
    if (w_boundary)     w_us_next = '0;
    else if (w_us_tick) w_us_next = r_us_cnt + 15'd1;
    else                w_us_next = r_us_cnt;
    w_tgt_x   = f_clamp(x_pulse_us);
    w_tgt_y   = f_clamp(y_pulse_us);
    w_wx_next = w_boundary ? f_slew(r_w_x, w_tgt_x) : r_w_x;
    w_wy_next = w_boundary ? f_slew(r_w_y, w_tgt_y) : r_w_y;
    w_en_next = w_boundary ? enable : r_en;
  end

  // State and pin registers; pins are decoded from next-state counters so the
  // rising edge lines up with the frame_start strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt     <= '0;
      r_us_cnt      <= '0;
      r_w_x         <= c_CENTER;
      r_w_y         <= c_CENTER;
      r_en          <= 1'b0;
      r_servo_x     <= 1'b0;
      r_servo_y     <= 1'b0;
      r_frame_start <= 1'b0;
      r_settled     <= 1'b0;
    end else begin
      r_pre_cnt     <= w_pre_next;
      r_us_cnt      <= w_us_next;
      r_w_x         <= w_wx_next;
      r_w_y         <= w_wy_next;
      r_en          <= w_en_next;
      r_servo_x     <= w_en_next && (w_us_next < {4'b0000, w_wx_next});
      r_servo_y     <= w_en_next && (w_us_next < {4'b0000, w_wy_next});
      r_frame_start <= w_boundary;
      if (w_boundary) begin
        r_settled <= (w_wx_next == w_tgt_x) && (w_wy_next == w_tgt_y);
      end
    end
  end

  assign servo_x     = r_servo_x;
  assign servo_y     = r_servo_y;
  assign frame_start = r_frame_start;
  assign settled     = r_settled;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_servo_pwm_gen
// Description : Scoreboard bench for servo_pwm_gen. Two instances share the
//               stimulus: one without slew limiting, one with 20 us steps.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_gen;

  localparam int TICKS  = 2;
  localparam int FRAME  = 2500;
  localparam int PERIOD = TICKS * FRAME;
  localparam int MINV   = 1000;
  localparam int MAXV   = 2000;
  localparam int STEP   = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] x_us = 11'd1500;
  logic [10:0] y_us = 11'd1500;
  logic [1:0]  sx, sy, fs, st;

  always #5 clk = ~clk;

  servo_pwm_gen #(.CLK_FREQ_HZ(2_000_000), .FRAME_US(FRAME), .STEP_US(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .x_pulse_us(x_us), .y_pulse_us(y_us),
    .servo_x(sx[0]), .servo_y(sy[0]), .frame_start(fs[0]), .settled(st[0]));

  servo_pwm_gen #(.CLK_FREQ_HZ(2_000_000), .FRAME_US(FRAME), .STEP_US(STEP)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .x_pulse_us(x_us), .y_pulse_us(y_us),
    .servo_x(sx[1]), .servo_y(sy[1]), .frame_start(fs[1]), .settled(st[1]));

  int checks = 0;
  int errors = 0;

  typedef struct {int hx; int hy; bit st;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   mw_x, mw_y;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, want);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v);
  endfunction

  function automatic int slewv(input int w, input int t);
    if (t > w) return (t - w > STEP) ? w + STEP : t;
    return (w - t > STEP) ? w - STEP : t;
  endfunction

  // Reference model: the inputs now on the pins are what the next boundary samples.
  task automatic push_expected();
    int   tx, ty;
    exp_t e;
    tx = clampv(int'(x_us));
    ty = clampv(int'(y_us));
    e.hx = enable ? tx * TICKS : 0;
    e.hy = enable ? ty * TICKS : 0;
    e.st = 1'b1;
    q0.push_back(e);
    mw_x = slewv(mw_x, tx);
    mw_y = slewv(mw_y, ty);
    e.hx = enable ? mw_x * TICKS : 0;
    e.hy = enable ? mw_y * TICKS : 0;
    e.st = (mw_x == tx) && (mw_y == ty);
    q1.push_back(e);
  endtask

  // Monitor state, one slot per instance.
  int cnt[2], hx[2], hy[2], badr[2];
  bit in_frame[2], st_s[2], px[2], py[2];

  task automatic finalize(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL d%0d_unexpected_frame actual=frame required=none", d);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("d%0d_period", d), cnt[d], PERIOD);
    check($sformatf("d%0d_x_high", d), hx[d], e.hx);
    check($sformatf("d%0d_y_high", d), hy[d], e.hy);
    check($sformatf("d%0d_settled", d), int'(st_s[d]), int'(e.st));
    check($sformatf("d%0d_stray_rise", d), badr[d], 0);
  endtask

  // Frame monitor: measures each complete frame and scores it against the queue.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        in_frame[d] = 1'b0;
        px[d] = 1'b0;
        py[d] = 1'b0;
      end else begin
        if (fs[d]) begin
          if (in_frame[d]) finalize(d);
          in_frame[d] = 1'b1;
          cnt[d] = 0; hx[d] = 0; hy[d] = 0; badr[d] = 0;
          st_s[d] = st[d];
        end else if ((sx[d] && !px[d]) || (sy[d] && !py[d])) begin
          badr[d]++;
        end
        if (in_frame[d]) begin
          cnt[d]++;
          hx[d] += int'(sx[d]);
          hy[d] += int'(sy[d]);
        end
        px[d] = sx[d];
        py[d] = sy[d];
      end
    end
  end

  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (!fs[0] && n < PERIOD + 10) begin
      @(negedge clk);
      n++;
    end
    if (!fs[0]) begin
      checks++;
      errors++;
      $display("FAIL frame_start_timeout actual=none required=strobe");
    end
  endtask

  // Entered at the negedge of a frame's first cycle; changes inputs o cycles later.
  task automatic frame_step(input int o, input bit en, input int x, input int y);
    if (o > 0) begin
      repeat (o) @(posedge clk);
      #1;
    end
    enable = en;
    x_us = 11'(x);
    y_us = 11'(y);
    push_expected();
    wait_fs();
  endtask

  task automatic check_reset_outs(input string name);
    check(name, int'({sx, sy, fs, st}), 0);
  endtask

  // Release reset, then require quiet pins until the first strobe one period later.
  task automatic release_and_check();
    int bad = 0;
    int lat = -1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= PERIOD + 5; i++) begin
      @(negedge clk);
      if (fs[0] != fs[1]) bad++;
      if (fs[0]) begin
        lat = i;
        break;
      end
      if (sx != 2'b00 || sy != 2'b00) bad++;
    end
    check("release_quiet_pins", bad, 0);
    check("release_first_strobe", lat, PERIOD);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    mw_x = 1500; mw_y = 1500;
    rst = 1'b1;
    enable = 1'b1; x_us = 11'd1200; y_us = 11'd1800;
    repeat (5) @(negedge clk);
    check_reset_outs("reset_outputs");
    push_expected();
    release_and_check();

    frame_step(1200, 1'b1, 1800, 1800);  // mid-pulse change at us_cnt=600
    frame_step(2000, 1'b1, 500, 2047);   // clamp both ways
    frame_step(4999, 1'b0, 1000, 2000);  // disable in the boundary cycle itself
    frame_step(300,  1'b0, 1700, 1300);
    frame_step(0,    1'b1, 999, 2001);   // re-enable right after a boundary
    frame_step($urandom_range(0, PERIOD - 1), ($urandom_range(0, 3) != 0),
               $urandom_range(1, 2047), $urandom_range(1, 2047));
    frame_step($urandom_range(0, PERIOD - 1), 1'b1,
               $urandom_range(1, 2047), $urandom_range(1, 2047));

    // Reset mid-pulse at us_cnt=300.
    repeat (600) @(posedge clk);
    #1;
    check("pulse_in_flight", int'(sx[0]), 1);
    rst = 1'b1;
    q0.delete();
    q1.delete();
    mw_x = 1500; mw_y = 1500;
    enable = 1'b1; x_us = 11'd1555; y_us = 11'd1500;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_reset_outs($sformatf("reset_mid_pulse_%0d", k));
    end
    push_expected();
    release_and_check();

    frame_step(100, 1'b1, 1555, 1500);   // slew 1520 -> 1540
    frame_step(100, 1'b1, 1555, 1500);   // slew 1540 -> 1555

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3 * PERIOD) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", q0.size() + q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
